// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, mul/div FSM state encoding and helpers
// Used by ula_ctrl (opcode generation) and ula_muldiv (execution).
package mips_pkg;
   localparam logic [3:0] OP_MULT = 4'b1100;
   localparam logic [3:0] OP_DIV  = 4'b1101;
   localparam logic [5:0] MD_ITERS = 6'd32;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} md_state_t;
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction
endpackage

// File: rtl/ula_muldiv.sv
// ula_muldiv: iterative 32-bit signed/unsigned multiply/divide writing HI/LO
// Ports: clk, rst (async active-high); start/OP/is_unsigned/In1/In2 request;
//        busy/done/div_by_zero status; HI/LO result registers (always readable).
module ula_muldiv
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  OP,
   input  logic        is_unsigned,
   input  logic [31:0] In1,
   input  logic [31:0] In2,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        div_by_zero
);
   md_state_t   state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] m_q, m_d, a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic        div_q, div_d, uns_q, uns_d, dbz_q, dbz_d;
   logic        accept, neg;
   logic [32:0] sum, trial;
   logic [63:0] prod;
   logic [31:0] quo, rem;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         div_q   <= 1'b0;
         uns_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         div_q   <= div_d;
         uns_q   <= uns_d;
         dbz_q   <= dbz_d;
      end
   end
   // acc holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV;
   // CALC count 0 is a setup cycle loading magnitudes, counts 1..32 are the iterations.
   always_comb begin
      accept  = state_q == S_IDLE && start && (OP == OP_MULT || OP == OP_DIV);
      neg     = !uns_q && (a_q[31] ^ b_q[31]);
      sum     = {1'b0, acc_q[63:32]} + {1'b0, m_q};
      trial   = acc_q[63:31] - {1'b0, m_q};
      prod    = neg ? -acc_q : acc_q;
      quo     = neg ? -acc_q[31:0] : acc_q[31:0];
      rem     = (!uns_q && a_q[31]) ? -acc_q[63:32] : acc_q[63:32];
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      m_d     = m_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_d   = div_q;
      uns_d   = uns_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            a_d     = In1;
            b_d     = In2;
            div_d   = OP == OP_DIV;
            uns_d   = is_unsigned;
            dbz_d   = 1'b0;
         end
         S_CALC: begin
            cnt_d   = cnt_q + 6'd1;
            state_d = cnt_q == MD_ITERS ? S_FIX : S_CALC;
            if (cnt_q == '0) begin
               acc_d = {32'b0, mag32(a_q, !uns_q)};
               m_d   = mag32(b_q, !uns_q);
            end else if (div_q)
               acc_d = trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
            else
               acc_d = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
         end
         S_FIX: begin
            state_d = S_DONE;
            if (div_q && b_q == '0) begin
               hi_d  = a_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else if (div_q) begin
               hi_d = rem;
               lo_d = quo;
            end else
               {hi_d, lo_d} = prod;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   assign busy        = state_q != S_IDLE;
   assign done        = state_q == S_DONE;
   assign HI          = hi_q;
   assign LO          = lo_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_ula_muldiv.sv
// tb_ula_muldiv: randomized self-checking bench for ula_muldiv against an arithmetic model
module tb_ula_muldiv;
   import mips_pkg::*;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, is_unsigned = 1'b0;
   logic [3:0]  OP = '0;
   logic [31:0] In1 = '0, In2 = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] HI, LO;
   int          n_vec = 0, n_err = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;
   ula_muldiv dut (
      .clk(clk), .rst(rst), .start(start), .OP(OP), .is_unsigned(is_unsigned),
      .In1(In1), .In2(In2), .busy(busy), .done(done), .HI(HI), .LO(LO),
      .div_by_zero(div_by_zero)
   );
   always #5 clk = ~clk;
   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic model(input logic [3:0] op, input logic u, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic z);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      z  = 1'b0;
      if (op == OP_MULT) begin
         p  = u ? {32'b0, a} * {32'b0, b} : 64'(sa * sb);
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 0) begin
         hi = a;
         lo = '1;
         z  = 1'b1;
      end else if (u) begin
         hi = a % b;
         lo = a / b;
      end else begin
         hi = 32'(sa % sb);
         lo = 32'(sa / sb);
      end
   endtask
   // call at a negedge; start is accepted at the following posedge (edge 0)
   task automatic run_op(input logic [3:0] op, input logic u, input logic [31:0] a,
                         input logic [31:0] b, input logic b2b);
      logic [31:0] mhi, mlo;
      logic        mz;
      int          early, idle;
      model(op, u, a, b, mhi, mlo, mz);
      OP = op; is_unsigned = u; In1 = a; In2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; In1 = $urandom; In2 = $urandom; OP = 4'($urandom); is_unsigned = 1'($urandom);
      chk("busy_after_accept", busy, 1);
      chk("dbz_clear_on_accept", div_by_zero, 0);
      early = 0; idle = 0;
      for (int e = 1; e < 34; e++) begin
         @(posedge clk); #1;
         early += int'(done);
         idle  += int'(!busy);
      end
      chk("no_early_done", early, 0);
      chk("busy_through_calc", idle, 0);
      chk("hilo_held_before_fix", {HI, LO}, {exp_hi, exp_lo});
      @(posedge clk); #1;
      chk("done_edge34", done, 1);
      chk("busy_edge34", busy, 1);
      chk("hi", HI, mhi);
      chk("lo", LO, mlo);
      chk("dbz", div_by_zero, mz);
      exp_hi = mhi; exp_lo = mlo;
      if (b2b) begin
         start = 1'b1; OP = OP_MULT;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_edge35", done, 0);
      chk("busy_edge35", busy, 0);
      chk("dbz_hold", div_by_zero, mz);
      chk("hilo_hold", {HI, LO}, {exp_hi, exp_lo});
      @(negedge clk);
   endtask
   initial begin
      logic [31:0] ra, rb;
      int          cnt;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", div_by_zero, 0);
      chk("rst_hilo", {HI, LO}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_op(OP_MULT, 1'b0, -32'sd3, 32'd7, 1'b0);
      run_op(OP_MULT, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      run_op(OP_DIV, 1'b0, -32'sd7, 32'd2, 1'b0);
      run_op(OP_DIV, 1'b1, 32'd100, 32'd7, 1'b1);
      run_op(OP_DIV, 1'b1, 32'd5, 32'd0, 1'b0);
      run_op(OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(OP_DIV, 1'b0, -32'sd9, 32'd0, 1'b0);
      run_op(OP_MULT, 1'b0, 32'h80000000, 32'h80000000, 1'b0);
      // illegal opcode must be ignored entirely
      OP = 4'b0010; start = 1'b1; In1 = 32'd3; In2 = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      for (int e = 0; e < 40; e++) begin
         cnt += int'(busy) + int'(done);
         @(posedge clk); #1;
      end
      chk("badop_idle", cnt, 0);
      chk("badop_hilo", {HI, LO}, {exp_hi, exp_lo});
      // reset in mid-operation aborts; a second start while busy is ignored
      @(negedge clk);
      OP = OP_MULT; is_unsigned = 1'b0; In1 = 32'd6; In2 = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1; In1 = 32'd2; In2 = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_hilo", {HI, LO}, 64'd0);
      chk("abort_done", done, 0);
      exp_hi = '0; exp_lo = '0;
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk); #1;
         cnt += int'(busy) + int'(done);
      end
      chk("abort_no_done", cnt, 0);
      @(negedge clk);
      run_op(OP_MULT, 1'b0, 32'd6, 32'd7, 1'b0);
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom_range(0, 7) == 0 ? 32'd0 :
              $urandom_range(0, 2) == 0 ? 32'($urandom_range(1, 9)) :
              $urandom_range(0, 3) == 0 ? -32'($urandom_range(1, 9)) : $urandom;
         run_op($urandom_range(0, 1) ? OP_DIV : OP_MULT, 1'($urandom), ra, rb, 1'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ula_muldiv.md
ULA_MULDIV -- requirements
Module: ula_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request pulse; sampled on clk rising edge.
REQ-004 SHALL have port OP, input, 4, operation code from ula_ctrl: 4'b1100 = multiply, 4'b1101 = divide.
REQ-005 SHALL have port is_unsigned, input, 1, 1 = MULTU/DIVU (func[0]), 0 = signed.
REQ-006 SHALL have ports In1 and In2, input, 32 each, multiplicand/dividend and multiplier/divisor.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports HI and LO, output, 32 each, result registers, continuously readable (MFHI/MFLO).
REQ-010 SHALL have port div_by_zero, output, 1, set with done when divisor was 0.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-012 IDLE -> CALC SHALL occur only when start=1 and OP is 1100 or 1101; otherwise start SHALL be ignored with no state or output change.
REQ-013 On acceptance, In1, In2, OP and is_unsigned SHALL be captured; later input changes SHALL NOT affect the result.
REQ-014 Signed operands SHALL be converted to magnitudes; CALC SHALL run exactly 32 iterations (one bit per cycle): shift-add multiply, restoring divide.
REQ-015 CALC -> FIX after iteration 32; FIX SHALL apply sign correction and write HI/LO; FIX -> DONE; DONE -> IDLE.
REQ-016 Latency: with start accepted at edge 0, HI/LO SHALL hold the new result and done=1 after edge 34; done=0 after edge 35.
REQ-017 busy SHALL be 1 from after edge 0 through the cycle done=1, inclusive; 0 otherwise.
REQ-018 start while busy=1 SHALL be ignored; back-to-back start in the DONE cycle SHALL also be ignored.
REQ-019 Multiply: {HI,LO} SHALL equal the full 64-bit product; signed product negated when operand signs differ.
REQ-020 Divide: LO = quotient, HI = remainder; signed quotient sign = XOR of operand signs, remainder sign = dividend sign.
REQ-021 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield LO=32'h80000000, HI=0, no flag.
REQ-022 Divisor 0: same latency, LO=32'hFFFFFFFF, HI=captured In1, div_by_zero=1 in done cycle; div_by_zero SHALL clear at next accepted start.
REQ-023 HI/LO SHALL change only in FIX or on reset.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, busy=0, done=0, div_by_zero=0, HI=0, LO=0, iteration counter and working registers 0.
REQ-025 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow deassertion.
REQ-026 First start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-027 OP codes (OP_MULT=4'b1100, OP_DIV=4'b1101) and the FSM state encoding SHALL live in shared package mips_pkg, also used by ula_ctrl.
REQ-028 SHALL be a single module with no sub-modules; a 6-bit iteration counter and 64-bit working register form the datapath.

Verification
REQ-029 MULT signed In1=-3, In2=7 -> after edge 34 HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, done=1 one cycle.
REQ-030 MULTU In1=In2=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-031 DIV signed In1=-7, In2=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-032 DIVU In1=5, In2=0 -> LO=32'hFFFFFFFF, HI=5, div_by_zero=1 with done at edge 34.
REQ-033 start MULT 6*7, second start at edge 5 with 2*2, rst pulse at edge 10 -> second ignored, HI=LO=0, busy=0, no done; new MULT 6*7 -> LO=42 after 34 edges.
REQ-034 start with OP=4'b0010 -> busy stays 0, no done, HI/LO unchanged.
